// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared constants for the nibble-serial add/subtract engine: FSM state
// encoding and the slice width processed per cycle.
package nibble_serial_add_ctrl_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Start/busy/done handshake plus operand and result bus for the
// nibble-serial adder. The master requests operations; the slave computes.
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_add_ctrl_adder4.sv
// Combinational 4-bit ripple-carry adder built from four full-adder stages.
// c3 exposes the carry into the top bit so the caller can derive signed
// overflow on the most significant nibble.
module nibble_adder4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[4];
  assign c3 = c[3];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract engine that reuses one 4-bit adder, least significant
// nibble first, chaining a registered carry between passes.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int NSLICE = WIDTH / NIBBLE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [NIBBLE-1:0]  nib_s;
  logic               nib_co;
  logic               nib_c3;
  logic               last_slice;

  nibble_adder4 u_adder (
    .x  (a_q[NIBBLE*idx_q +: NIBBLE]),
    .y  (b_q[NIBBLE*idx_q +: NIBBLE]),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co),
    .c3 (nib_c3)
  );

  assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

  // Next-state: accept in IDLE/DONE, one nibble pass per cycle in RUN.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          // Subtraction is A + ~B + 1: invert B here, seed the carry with 1.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[NIBBLE*idx_q +: NIBBLE] = nib_s;
        carry_d = nib_co;
        if (last_slice) begin
          cout_d  = nib_co;
          ovf_d   = nib_c3 ^ nib_co;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Testbench for nibble_serial_add_ctrl (WIDTH=16): directed vector table,
// handshake/reset corner sequences, and random operations against an
// arithmetic reference model.
module tb_nibble_serial_add_ctrl;
  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic clk;
  logic rst;

  nibble_serial_add_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; overflow = signed result out of range.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                input logic mcin, input logic msub,
                                output logic [15:0] s, output logic c, output logic o);
    int ua, ub, r, sa, sb, sr;
    ua = int'(ma);
    ub = int'(mb);
    sa = $signed(ma);
    sb = $signed(mb);
    if (msub) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + int'(mcin);
      c  = (r > 65535);
      sr = sa + sb + int'(mcin);
    end
    s = r[15:0];
    o = (sr > 32767) || (sr < -32768);
  endfunction

  // Waits (bounded) for done, dropping start after the accept edge.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      bus_if.start = 1'b0;
      lat++;
      if (bus_if.busy) nbusy++;
      if (bus_if.busy && bus_if.done) chk("busy_done_exclusive", 1, 0);
    end while (!bus_if.done && lat < 20);
  endtask

  task automatic drive(input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tcin, input logic tsub);
    bus_if.start = 1'b1;
    bus_if.a     = ta;
    bus_if.b     = tb_v;
    bus_if.cin   = tcin;
    bus_if.sub   = tsub;
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tcin, input logic tsub,
                        output int lat, output int nbusy);
    @(negedge clk);
    drive(ta, tb_v, tcin, tsub);
    wait_done(lat, nbusy);
  endtask

  initial begin
    int lat, nbusy;
    logic [15:0] ms;
    logic mc, mo;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

    rst = 1'b1;
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    bus_if.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", bus_if.busy, 0);
    chk("reset_done", bus_if.done, 0);
    chk("reset_sum",  bus_if.sum,  0);
    chk("reset_cout", bus_if.cout, 0);
    chk("reset_ovf",  bus_if.ovf,  0);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat, nbusy);
      chk($sformatf("vec%0d_latency", i), lat, NSLICE + 1);
      chk($sformatf("vec%0d_busy_cycles", i), nbusy, NSLICE);
      chk($sformatf("vec%0d_sum", i), bus_if.sum, vecs[i].exp_sum);
      chk($sformatf("vec%0d_cout", i), bus_if.cout, vecs[i].exp_cout);
      chk($sformatf("vec%0d_ovf", i), bus_if.ovf, vecs[i].exp_ovf);
    end

    // Start pulsed during the 2nd RUN cycle must be ignored
    @(negedge clk);
    drive(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    chk("inject_in_run_busy", bus_if.busy, 1);
    drive(16'h1111, 16'h1111, 1'b0, 1'b0);
    wait_done(lat, nbusy);
    chk("inject_latency", lat, NSLICE - 1);
    chk("inject_sum", bus_if.sum, 16'h2233);
    // Idle stability
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", bus_if.busy, 0);
      chk("idle_done", bus_if.done, 0);
      chk("idle_sum",  bus_if.sum,  16'h2233);
    end

    // Back-to-back accept in the DONE cycle
    run_op(16'h0005, 16'h0003, 1'b0, 1'b0, lat, nbusy);
    chk("b2b_first_sum", bus_if.sum, 16'h0008);
    drive(16'h0001, 16'h0002, 1'b0, 1'b0);
    wait_done(lat, nbusy);
    chk("b2b_latency", lat, NSLICE + 1);
    chk("b2b_busy_cycles", nbusy, NSLICE);
    chk("b2b_sum", bus_if.sum, 16'h0003);

    // Reset in the 2nd RUN cycle (prior op leaves cout/ovf set)
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat, nbusy);
    chk("pre_reset_ovf", bus_if.ovf, 1);
    @(negedge clk);
    drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", bus_if.busy, 0);
    chk("midrst_done", bus_if.done, 0);
    chk("midrst_sum",  bus_if.sum,  0);
    chk("midrst_cout", bus_if.cout, 0);
    chk("midrst_ovf",  bus_if.ovf,  0);
    begin
      int seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (bus_if.done || bus_if.busy) seen++;
      end
      chk("midrst_no_done", seen, 0);
    end
    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, lat, nbusy);
    chk("post_rst_latency", lat, NSLICE + 1);
    chk("post_rst_sum", bus_if.sum, 16'h2233);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      logic rc, rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rc, rs, ms, mc, mo);
      run_op(ra, rb, rc, rs, lat, nbusy);
      chk($sformatf("rnd%0d_latency", i), lat, NSLICE + 1);
      chk($sformatf("rnd%0d_sum", i), bus_if.sum, ms);
      chk($sformatf("rnd%0d_cout", i), bus_if.cout, mc);
      chk($sformatf("rnd%0d_ovf", i), bus_if.ovf, mo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs one WIDTH-bit add or subtract by reusing a single 4-bit ripple-carry nibble adder once per cycle, least significant nibble first. A registered carry is chained between nibbles. The block trades latency for area. Other blocks drive it through a start/busy/done handshake, and it is the wide-add engine for datapaths that cannot afford a full-width adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
NSLICE, WIDTH/4, derived localparam: number of nibble passes per operation

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  request an operation; sampled only when accepting (see Behaviour)
a  in  WIDTH  operand A; sampled on the accept edge only
b  in  WIDTH  operand B; sampled on the accept edge only
cin  in  1  carry-in for add; ignored when sub=1
sub  in  1  0 = A+B+cin, 1 = A-B (computed as A + ~B + 1)
busy  out  1  high while in RUN
done  out  1  one-cycle pulse; sum/cout/ovf are valid from this cycle
sum  out  WIDTH  result, held until the next accept or reset
cout  out  1  carry out of the MSB; for subtract, 1 = no borrow
ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset: with rst=1 at a rising edge, the state goes to IDLE and busy, done, sum, cout, ovf, the nibble counter and the carry register all become 0. Reset takes priority over everything, including mid-RUN; no partial result is kept.
- States: IDLE, RUN, DONE.
- Accept: start=1 at an edge while in IDLE or DONE. On that edge:
  - latch a into A_reg;
  - latch b into B_reg, or ~b when sub=1;
  - carry_reg <= (sub ? 1 : cin);
  - idx <= 0; sum <= 0; state <= RUN.
- start is ignored while in RUN; operand inputs are don't-care outside the accept edge.
- RUN, each edge:
  - the nibble adder gets A_reg[4*idx+3:4*idx], B_reg[4*idx+3:4*idx] and carry_reg;
  - its 4-bit result is written into sum[4*idx+3:4*idx] and its carry-out into carry_reg;
  - idx increments.
- On the edge processing idx = NSLICE-1:
  - cout <= nibble carry-out;
  - ovf <= nibble c3 XOR nibble carry-out, where c3 is the internal carry into bit 3;
  - state <= DONE; idx wraps to 0.
- DONE lasts exactly one cycle with done=1. The next edge goes to RUN if start=1 (back-to-back accept), otherwise to IDLE.
- Latency: accept at edge k, done=1 in the cycle after edge k+NSLICE. Back-to-back throughput is one result per NSLICE+1 cycles.
- busy=1 exactly in RUN. done and busy are never high together.
- Outputs are registered; no combinational path from inputs to outputs.
- Arithmetic: all WIDTH-bit modulo 2^WIDTH. With sub=1, cout=1 means A >= B unsigned.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=0, ST_RUN=1, ST_DONE=2, 2-bit) and the NIBBLE=4 constant.
- idx width is $clog2(NSLICE), with a minimum of 1.
- One sub-module: nibble_adder4.
  - Combinational 4-bit ripple-carry adder built from four 1-bit full-adder stages.
  - Ports: x[3:0], y[3:0], ci, s[3:0], co, c3, where c3 is the carry into bit 3.
  - Instantiated exactly once.
- The controller holds the FSM, operand registers, carry register, counter and result assembly.

Test Plan:
- Reset, then add with WIDTH=16: a=0x1234, b=0x0FFF, cin=0, sub=0, start for 1 cycle. Required: busy high for 4 cycles, then done=1 for 1 cycle, with sum=0x2233, cout=0, ovf=0. done must come exactly 4 edges after the accept edge.
- Carry ripple across all nibbles: a=0xFFFF, b=0x0001, cin=0. Required: sum=0x0000, cout=1, ovf=0. Then a=0x0000, b=0x0000, cin=1: sum=0x0001, cout=0.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1. Required: sum=0xFFFE, cout=0 (borrow), ovf=0; cin is ignored. Then a=0x0007, b=0x0005: sum=0x0002, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001, add. Required: sum=0x8000, ovf=1, cout=0. Then sub with a=0x8000, b=0x0001: sum=0x7FFF, ovf=1, cout=1.
- Handshake:
  - pulse start with new operands (0x1111+0x1111) during the 2nd RUN cycle of an operation; it is ignored, and the first result is unchanged;
  - hold start=1 in the DONE cycle with 0x0001+0x0002; it is accepted, and the next done shows sum=0x0003;
  - sum stays stable while idle.
- Reset mid-operation: assert rst for 1 cycle in the 2nd RUN cycle. Required after that edge: state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and no done pulse follows. A fresh start then completes normally in 4+1 cycles.
